// File: rtl/corevx_mem_arbiter.sv
// corevx_mem_arbiter: icache/dcache memory ports onto one memory port.
// Define COREVX_ARB_ROUND_ROBIN_EN for round-robin ties (else m0 wins).
module corevx_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] m0_address,
  input  logic [4:0]  m0_burstcount,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  output logic [1:0]  m0_response,
  input  logic [33:0] m1_address,
  input  logic [4:0]  m1_burstcount,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [1:0]  m1_response,
  output logic [33:0] mem_address,
  output logic [4:0]  mem_burstcount,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  input  logic [1:0]  mem_response
);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        gnt;
  logic        gnt_nx;
  logic [4:0]  beats;
  logic [4:0]  beats_nx;
  logic        is_read;
  logic        is_read_nx;
  logic        accepted;
  logic        accepted_nx;

  logic        req0;
  logic        req1;
  logic        win;
  logic [4:0]  win_bc;
  logic        busy;
  logic        rd_acc;
  logic        wr_acc;
  logic        rd_beat;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef COREVX_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  assign win = (req0 & req1) ? ~last_gnt : ~req0;

  // last-grant flag: the master granted most recently loses the next tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && (req0 | req1)) begin
      last_gnt <= win;
    end
  end
`else
  assign win = ~req0;
`endif

  assign win_bc = win ? m1_burstcount : m0_burstcount;
  assign busy   = (state == GRANTED);

  // granted master drives the memory command; read is issued only once
  always_comb begin
    mem_address    = '0;
    mem_burstcount = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (busy) begin
      mem_address    = gnt ? m1_address : m0_address;
      mem_burstcount = gnt ? m1_burstcount : m0_burstcount;
      mem_writedata  = gnt ? m1_writedata : m0_writedata;
      mem_byteenable = gnt ? m1_byteenable : m0_byteenable;
      mem_read       = is_read & ~accepted & (gnt ? m1_read : m0_read);
      mem_write      = ~is_read & (gnt ? m1_write : m0_write);
    end
  end

  assign rd_acc  = mem_read & ~mem_waitrequest;
  assign wr_acc  = mem_write & ~mem_waitrequest;
  assign rd_beat = busy & is_read & mem_readdatavalid;

  assign m0_waitrequest   = ~(busy & ~gnt) | mem_waitrequest;
  assign m1_waitrequest   = ~(busy & gnt) | mem_waitrequest;
  assign m0_readdatavalid = rd_beat & ~gnt;
  assign m1_readdatavalid = rd_beat & gnt;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_response      = mem_response;
  assign m1_response      = mem_response;

  // next-state: arbitrate in IDLE, count beats until the burst completes
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    beats_nx    = beats;
    is_read_nx  = is_read;
    accepted_nx = accepted;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx    = GRANTED;
          gnt_nx      = win;
          beats_nx    = (win_bc == 5'd0) ? 5'd1 : win_bc;
          is_read_nx  = win ? m1_read : m0_read;
          accepted_nx = 1'b0;
        end
      end
      GRANTED: begin
        if (rd_acc) begin
          accepted_nx = 1'b1;
        end
        if ((is_read && rd_beat) || (!is_read && wr_acc)) begin
          if (beats == 5'd1) begin
            state_nx = IDLE;
          end else begin
            beats_nx = beats - 5'd1;
          end
        end
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      beats    <= 5'd0;
      is_read  <= 1'b0;
      accepted <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      beats    <= beats_nx;
      is_read  <= is_read_nx;
      accepted <= accepted_nx;
    end
  end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// tb_corevx_mem_arbiter: vector table plus directed sequences,
// with a memory model and per-master scoreboards.
module tb_corevx_mem_arbiter;

`ifdef COREVX_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [33:0] ma[2];
  logic [4:0]  mbc[2];
  logic        mrd[2];
  logic        mwr[2];
  logic [31:0] mwd[2];
  logic [3:0]  mbe[2];
  logic        wreq[2];
  logic        rdv[2];
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_resp, m1_resp;

  logic [33:0] mem_address;
  logic [4:0]  mem_burstcount;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [1:0]  mem_response;

  corevx_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(ma[0]), .m0_burstcount(mbc[0]),
    .m0_read(mrd[0]), .m0_write(mwr[0]),
    .m0_writedata(mwd[0]), .m0_byteenable(mbe[0]),
    .m0_waitrequest(wreq[0]), .m0_readdata(m0_rdata),
    .m0_readdatavalid(rdv[0]), .m0_response(m0_resp),
    .m1_address(ma[1]), .m1_burstcount(mbc[1]),
    .m1_read(mrd[1]), .m1_write(mwr[1]),
    .m1_writedata(mwd[1]), .m1_byteenable(mbe[1]),
    .m1_waitrequest(wreq[1]), .m1_readdata(m1_rdata),
    .m1_readdatavalid(rdv[1]), .m1_response(m1_resp),
    .mem_address(mem_address), .mem_burstcount(mem_burstcount),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_response(mem_response)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [65:0] act,
                     input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected expected=event", name);
  endtask

  // memory model: 512 words, reads return one beat per cycle
  logic [31:0] mem_arr[512];
  logic        init_mem;
  logic        stall_en;
  logic [4:0]  rcnt, wcnt;
  logic [8:0]  ridx, wb_lat, w_idx;
  logic        stalled;
  int          err_idx = 40;

  assign mem_waitrequest = stall_en && !stalled &&
                           (wcnt == 5'd2 || wcnt == 5'd5);
  assign w_idx = (wcnt == 5'd0) ? mem_address[10:2] : wb_lat;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem_arr[i] <= 32'hA000_0000 + 32'(i);
      rcnt <= '0;
      wcnt <= '0;
      stalled <= 1'b0;
      mem_readdatavalid <= 1'b0;
      mem_readdata <= '0;
      mem_response <= '0;
    end else begin
      mem_readdatavalid <= 1'b0;
      if (rcnt != 5'd0) begin
        mem_readdatavalid <= 1'b1;
        mem_readdata <= mem_arr[ridx];
        mem_response <= (int'(ridx) == err_idx) ? 2'b11 : 2'b00;
        ridx <= ridx + 9'd1;
        rcnt <= rcnt - 5'd1;
      end
      if (mem_read && !mem_waitrequest) begin
        ridx <= mem_address[10:2];
        rcnt <= (mem_burstcount == 5'd0) ? 5'd1 : mem_burstcount;
      end
      if (mem_write) begin
        if (mem_waitrequest) begin
          stalled <= 1'b1;
        end else begin
          stalled <= 1'b0;
          mem_arr[w_idx + 9'(wcnt)] <= mem_writedata;
          if (wcnt == 5'd0) wb_lat <= mem_address[10:2];
          if (wcnt + 5'd1 >= ((mem_burstcount == 5'd0) ? 5'd1 : mem_burstcount))
            wcnt <= 5'd0;
          else
            wcnt <= wcnt + 5'd1;
        end
      end
    end
  end

  // scoreboards
  logic [33:0] rq0[$], rq1[$];
  logic [65:0] wq0[$], wq1[$];
  bit          gq[$];
  logic        prev_cmd = 1'b0;

  always @(negedge clk) begin
    logic [65:0] e;
    logic        cmd;
    cmd = mem_read | mem_write;
    if (cmd && !prev_cmd) begin
      if (gq.size() == 0) fail("grant_unexpected");
      else chk("grant_order", 66'(mem_address[10]), 66'(gq.pop_front()));
    end
    prev_cmd <= cmd;
    if (cmd && rst_n)
      chk("other_wait", 66'(mem_address[10] ? wreq[0] : wreq[1]), 66'd1);
    if (rdv[0] && rdv[1]) fail("both_rdv");
    if (rdv[0]) begin
      if (rq0.size() == 0) fail("rdv0_unexpected");
      else begin
        e = 66'(rq0.pop_front());
        chk("rd0", 66'({m0_resp, m0_rdata}), e);
      end
    end
    if (rdv[1]) begin
      if (rq1.size() == 0) fail("rdv1_unexpected");
      else begin
        e = 66'(rq1.pop_front());
        chk("rd1", 66'({m1_resp, m1_rdata}), e);
      end
    end
    if (mem_write && !mem_waitrequest) begin
      chk("wr_be", 66'(mem_byteenable), 66'hF);
      if (mem_address[10]) begin
        if (wq1.size() == 0) fail("wr1_unexpected");
        else chk("wr1", {mem_address, mem_writedata}, wq1.pop_front());
      end else begin
        if (wq0.size() == 0) fail("wr0_unexpected");
        else chk("wr0", {mem_address, mem_writedata}, wq0.pop_front());
      end
    end
  end

  task automatic wait_acc(input int m, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!wreq[m]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("accept_timeout");
  endtask

  task automatic burst(input int m, input bit rd, input int widx,
                       input int bc, input logic [31:0] wbase);
    int nb;
    int idx;
    bit ok;
    logic [33:0] a;
    nb = (bc == 0) ? 1 : bc;
    a = 34'(m * 1024 + widx * 4);
    ma[m] = a;
    mbc[m] = bc[4:0];
    mbe[m] = 4'hF;
    if (rd) begin
      for (int i = 0; i < nb; i++) begin
        idx = m * 256 + widx + i;
        if (m == 0) rq0.push_back({(idx == err_idx) ? 2'b11 : 2'b00, mem_arr[idx]});
        else rq1.push_back({(idx == err_idx) ? 2'b11 : 2'b00, mem_arr[idx]});
      end
      mrd[m] = 1'b1;
      wait_acc(m, ok);
      mrd[m] = 1'b0;
      if (ok) begin
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if ((m == 0 ? rq0.size() : rq1.size()) == 0) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) fail("read_beats_timeout");
      end
    end else begin
      for (int i = 0; i < nb; i++) begin
        mwd[m] = wbase + 32'(i);
        mwr[m] = 1'b1;
        if (m == 0) wq0.push_back({a, mwd[m]});
        else wq1.push_back({a, mwd[m]});
        wait_acc(m, ok);
        if (!ok) break;
      end
      mwr[m] = 1'b0;
    end
  endtask

  typedef struct {
    bit en0; bit rd0; int bc0; int a0;
    bit en1; bit rd1; int bc1; int a1;
    logic [31:0] wd; bit first;
  } vec_t;

  vec_t vt[6];
  vec_t v;
  bit   exp_last;
  bit   w;
  bit   ok_all;

  initial begin
    vt[0] = '{1, 1, 4, 0,  0, 0, 0, 0,  32'h0, 0};
    vt[1] = '{1, 1, 1, 8,  1, 0, 1, 4,  32'hABCD1234, 0};
    vt[2] = '{0, 0, 0, 0,  1, 1, 2, 16, 32'h0, 1};
    vt[3] = '{1, 0, 3, 32, 1, 1, 2, 4,  32'h5555_0000, 0};
    vt[4] = '{1, 1, 0, 40, 0, 0, 0, 0,  32'h0, 0};
    vt[5] = '{1, 1, 2, 48, 1, 1, 3, 48, 32'h0, 0};

    rst_n = 1'b0;
    init_mem = 1'b1;
    stall_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ma[m] = 34'h123 + 34'(m);
      mbc[m] = 5'd3;
      mrd[m] = 1'b0;
      mwr[m] = 1'b0;
      mwd[m] = 32'hFFFF_0000;
      mbe[m] = 4'hF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", 66'({mem_read, mem_write}), 66'd0);
    chk("rst_addr", 66'(mem_address), 66'd0);
    chk("rst_fields", 66'({mem_burstcount, mem_writedata, mem_byteenable}), 66'd0);
    chk("rst_wreq", 66'({wreq[0], wreq[1]}), 66'b11);
    chk("rst_rdv", 66'({rdv[0], rdv[1]}), 66'd0);
    rst_n = 1'b1;
    init_mem = 1'b0;
    exp_last = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      v = vt[r];
      if (v.en0 && v.en1) begin
        w = RR_EN ? !exp_last : v.first;
        gq.push_back(w);
        gq.push_back(!w);
        exp_last = !w;
      end else begin
        gq.push_back(v.first);
        exp_last = v.first;
      end
      fork
        begin if (v.en0) burst(0, v.rd0, v.a0, v.bc0, v.wd); end
        begin if (v.en1) burst(1, v.rd1, v.a1, v.bc1, v.wd); end
      join
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_burst",
          66'({wreq[0], wreq[1], mem_read, mem_write}), 66'b1100);
      @(posedge clk);
      #1;
    end
    chk("mem_abcd", 66'(mem_arr[260]), 66'h0ABCD1234);
    chk("mem_m0_wr", 66'({mem_arr[32], mem_arr[34]}), {2'b00, 32'h5555_0000, 32'h5555_0002});

    // repeated bursts from both masters
    for (int k = 0; k < 4; k++) begin
      if (RR_EN) begin
        w = !exp_last;
        exp_last = w;
      end else begin
        w = (k >= 2);
      end
      gq.push_back(w);
    end
    fork
      begin burst(0, 1, 64, 2, 0); burst(0, 1, 66, 2, 0); end
      begin burst(1, 1, 64, 1, 0); burst(1, 1, 65, 1, 0); end
    join
    if (!RR_EN) exp_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // write burst 8 with two stalls
    stall_en = 1'b1;
    gq.push_back(1'b1);
    exp_last = 1'b1;
    burst(1, 0, 100, 8, 32'hC0DE_0000);
    stall_en = 1'b0;
    ok_all = 1'b1;
    for (int i = 0; i < 8; i++)
      if (mem_arr[356 + i] !== 32'hC0DE_0000 + 32'(i)) ok_all = 1'b0;
    chk("wr8_contents", 66'(ok_all), 66'd1);
    repeat (2) @(posedge clk);
    #1;

    // reset during beat 2 of a 4-beat read
    gq.push_back(1'b0);
    rq0.push_back({2'b00, mem_arr[80]});
    rq0.push_back({2'b00, mem_arr[81]});
    ma[0] = 34'(80 * 4);
    mbc[0] = 5'd4;
    mrd[0] = 1'b1;
    wait_acc(0, w);
    mrd[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd", 66'({mem_read, mem_write}), 66'd0);
    chk("rst_mid_wreq", 66'({wreq[0], wreq[1]}), 66'b11);
    chk("rst_mid_rdv", 66'({rdv[0], rdv[1]}), 66'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_beats", 66'(rq0.size()), 66'd2 - 66'd2);
    exp_last = 1'b1;
    gq.push_back(1'b1);
    burst(1, 1, 200, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty",
        66'(rq0.size() + rq1.size() + wq0.size() + wq1.size() + gq.size()),
        66'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/corevx_mem_arbiter.md
# corevx_mem_arbiter

Two-master to one-slave arbiter on the memory side of the core. It merges the instruction-cache and data-cache `corevx_cache` memory ports (34-bit address, burst-capable, waitrequest/readdatavalid/response handshake) onto the single external memory port. Grant is held for a complete burst, so read beats and write beats are never interleaved between masters.

## Interface
Parameters: none (widths fixed by the cache memory port).

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m0_address, m1_address  in  34  master byte address (m0 = icache, m1 = dcache)
- m0_burstcount, m1_burstcount  in  5  beats in burst, 1..16; 0 treated as 1
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request (one beat per accepted cycle)
- m0_writedata, m1_writedata  in  32  write data
- m0_byteenable, m1_byteenable  in  4  byte lanes
- m0_waitrequest, m1_waitrequest  out  1  1 = command/beat not accepted
- m0_readdata, m1_readdata  out  32  read data, copy of mem_readdata
- m0_readdatavalid, m1_readdatavalid  out  1  read beat valid, granted master only
- m0_response, m1_response  out  2  copy of mem_response (00 OK, 11 error)
- mem_address  out  34; mem_burstcount  out  5; mem_read, mem_write  out  1; mem_writedata  out  32; mem_byteenable  out  4
- mem_waitrequest  in  1; mem_readdata  in  32; mem_readdatavalid  in  1; mem_response  in  2

## Operation
- States: IDLE, GRANTED.
- IDLE: mem_read = mem_write = 0, both mX_waitrequest = 1. A master requests when read|write. If any request exists, register grant (gnt = 0/1), load beats = burstcount (0 → 1), is_read = read, accepted = 0, go to GRANTED.
- Arbitration: with COREVX_ARB_ROUND_ROBIN_EN, when both masters request, the one not granted last wins; otherwise fixed priority, m0 wins.
- GRANTED: the granted master's address/burstcount/read/write/writedata/byteenable drive mem_* combinationally; mem_waitrequest passes to it; the other master sees waitrequest = 1 and readdatavalid = 0.
- Read: command accepted on mem_read & !mem_waitrequest; after acceptance mem_read is forced to 0 (command not reissued). Each mem_readdatavalid decrements beats; the last beat (beats == 1) returns to IDLE. A beat in the same cycle as acceptance counts.
- Write: each mem_write & !mem_waitrequest decrements beats; the last accepted beat returns to IDLE. If the master drops write mid-burst, grant is held until it is complete.
- mem_readdatavalid while not GRANTED-reading is dropped (not forwarded).
- readdata/response are broadcast to both ports; only readdatavalid and waitrequest qualify them.

## Timing
- Reset values: state IDLE, mem_read = mem_write = 0, mem_address = 0, mem_burstcount = 0, mem_writedata = 0, mem_byteenable = 0, mX_waitrequest = 1, mX_readdatavalid = 0, last-grant = m1 (so m0 wins first tie).
- Request first seen at edge N → mem_* driven during cycle N+1 (one-cycle arbitration latency).
- End of burst at edge M → IDLE during M+1; a new grant is visible at M+2 (one bubble between bursts).
- Masters hold the command stable until waitrequest = 0 (Avalon rule); the arbiter does not register command fields other than burst length and direction.
- Reset asserted mid-burst: the burst is abandoned, all outputs return to reset values at the next edge, and outstanding memory beats are discarded.

## Configuration
- COREVX_ARB_ROUND_ROBIN_EN defined: round-robin between the two masters using a last-grant flag updated at each grant.
- Not defined: fixed priority, m0 (icache) always wins ties; the last-grant flag is not implemented.

## Test plan
- Single m0 read, burstcount 4, memory returns A0..A3 → m0 gets 4 readdatavalid beats with A0..A3, m1_readdatavalid stays 0, IDLE after beat 4.
- m0 read (burst 1) and m1 write (burst 1, 0xABCD1234, be 4'hF) requested at the same edge, RR enabled → m0 served first, then m1; memory word holds 0xABCD1234 afterwards.
- Both masters issue repeated bursts, RR enabled → grants alternate m0, m1, m0, m1; with the macro undefined, m0 starves m1 while it keeps requesting.
- m1 write burst 8 with waitrequest stalls on beats 3 and 6 → exactly 8 beats are written in order; m0 waitrequest stays 1 throughout.
- Read with burstcount 0 → treated as 1 beat; mem_response 2'b11 on that beat → forwarded unchanged to the granted master, arbiter returns to IDLE.
- rst_n low during beat 2 of a 4-beat read → mem_read = 0, both waitrequests = 1 next cycle; a fresh m1 read afterwards completes normally.
